// File: rtl/bsg_gateway_wh_conc_arbiter_if.sv
// bsg_gateway_wh_conc_arbiter_if: request, response and error signals between the links and the concentrator
interface bsg_gateway_wh_conc_arbiter_if #(
  parameter int num_in_p = 4,
  parameter int flit_width_p = 32
);
  logic [num_in_p-1:0] in_v_i;
  logic [num_in_p-1:0][flit_width_p-1:0] in_data_i;
  logic [num_in_p-1:0] in_ready_and_o;
  logic out_v_o;
  logic [flit_width_p-1:0] out_data_o;
  logic out_ready_and_i;
  logic rsp_v_i;
  logic [flit_width_p-1:0] rsp_data_i;
  logic rsp_ready_and_o;
  logic [num_in_p-1:0] rsp_v_o;
  logic [flit_width_p-1:0] rsp_data_o;
  logic [num_in_p-1:0] rsp_ready_and_i;
  logic rsp_err_o;
  modport slave (
    input in_v_i, in_data_i, out_ready_and_i, rsp_v_i, rsp_data_i, rsp_ready_and_i,
    output in_ready_and_o, out_v_o, out_data_o, rsp_ready_and_o, rsp_v_o, rsp_data_o, rsp_err_o
  );
  modport master (
    output in_v_i, in_data_i, out_ready_and_i, rsp_v_i, rsp_data_i, rsp_ready_and_i,
    input in_ready_and_o, out_v_o, out_data_o, rsp_ready_and_o, rsp_v_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/bsg_gateway_wh_conc_arbiter.sv
// bsg_gateway_wh_conc_arbiter: packet-locked round-robin wormhole concentrator with cid-routed responses
module bsg_gateway_wh_conc_arbiter #(
  parameter int num_in_p = 4,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 5,
  parameter int len_width_p = 4,
  parameter int cid_width_p = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_gateway_wh_conc_arbiter_if.slave io
);
  localparam int ptr_w = $clog2(num_in_p);
  localparam int len_lo = cord_width_p;
  localparam int cid_lo = cord_width_p + len_width_p;
  localparam logic [flit_width_p-1:0] cid_mask = flit_width_p'({cid_width_p{1'b1}}) << cid_lo;
  localparam logic [1:0] FWD_IDLE = 2'd0, FWD_HOLD = 2'd1, FWD_BODY = 2'd2;
  localparam logic [1:0] RSP_IDLE = 2'd0, RSP_BODY = 2'd1, RSP_DROP = 2'd2;
  logic [1:0] fwd_st, rsp_st;
  logic [ptr_w-1:0] rr_ptr, hold_g, rr_g, k, g, g_nxt, rsp_d, rd;
  logic [len_width_p-1:0] fwd_cnt, rsp_cnt, fwd_len, rsp_len;
  logic [cid_width_p-1:0] d;
  logic [flit_width_p-1:0] flit;
  logic hdr, fwd_xfer, bad, drop, rsp_xfer, rsp_err;
  always_comb begin
    rr_g = rr_ptr;
    k = '0;
    for (int i = num_in_p - 1; i >= 0; i--) begin
      k = ptr_w'((int'(rr_ptr) + i) % num_in_p);
      if (io.in_v_i[k]) rr_g = k;
    end
  end
  assign hdr = fwd_st != FWD_BODY;
  assign g = (fwd_st == FWD_IDLE) ? rr_g : hold_g;
  assign g_nxt = (int'(g) == num_in_p - 1) ? '0 : g + 1'b1;
  assign flit = io.in_data_i[g];
  assign fwd_len = flit[len_lo +: len_width_p];
  assign io.out_v_o = reset_n_i & ((fwd_st == FWD_IDLE) ? |io.in_v_i : io.in_v_i[g]);
  assign io.out_data_o = hdr ? (flit & ~cid_mask) | (flit_width_p'(g) << cid_lo) : flit;
  assign io.in_ready_and_o = (reset_n_i & io.out_ready_and_i) ? num_in_p'(1) << g : '0;
  assign fwd_xfer = io.out_v_o & io.out_ready_and_i;
  // hold_g doubles as the body lock, so one register covers both HOLD and BODY
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      fwd_st <= FWD_IDLE;
      rr_ptr <= '0;
      hold_g <= '0;
      fwd_cnt <= '0;
    end else if (fwd_st == FWD_BODY) begin
      if (fwd_xfer) begin
        fwd_cnt <= fwd_cnt - 1'b1;
        if (fwd_cnt == len_width_p'(1)) fwd_st <= FWD_IDLE;
      end
    end else if (fwd_xfer) begin
      rr_ptr <= g_nxt;
      hold_g <= g;
      fwd_cnt <= fwd_len;
      fwd_st <= (fwd_len == '0) ? FWD_IDLE : FWD_BODY;
    end else if (io.out_v_o) begin
      hold_g <= g;
      fwd_st <= FWD_HOLD;
    end
  assign d = io.rsp_data_i[cid_lo +: cid_width_p];
  assign rsp_len = io.rsp_data_i[len_lo +: len_width_p];
  assign bad = int'(d) >= num_in_p;
  assign rd = (rsp_st == RSP_IDLE) ? d[ptr_w-1:0] : rsp_d;
  assign drop = (rsp_st == RSP_IDLE) ? bad : (rsp_st == RSP_DROP);
  assign io.rsp_v_o = (reset_n_i & io.rsp_v_i & ~drop) ? num_in_p'(1) << rd : '0;
  assign io.rsp_ready_and_o = reset_n_i & (drop | io.rsp_ready_and_i[rd]);
  assign io.rsp_data_o = io.rsp_data_i;
  assign io.rsp_err_o = rsp_err;
  assign rsp_xfer = io.rsp_v_i & io.rsp_ready_and_o;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rsp_st <= RSP_IDLE;
      rsp_d <= '0;
      rsp_cnt <= '0;
      rsp_err <= 1'b0;
    end else if (rsp_st == RSP_IDLE) begin
      if (rsp_xfer) begin
        rsp_err <= rsp_err | bad;
        rsp_d <= rd;
        rsp_cnt <= rsp_len;
        if (rsp_len != '0) rsp_st <= bad ? RSP_DROP : RSP_BODY;
      end
    end else if (rsp_xfer) begin
      rsp_cnt <= rsp_cnt - 1'b1;
      if (rsp_cnt == len_width_p'(1)) rsp_st <= RSP_IDLE;
    end
endmodule

// File: tb/tb_bsg_gateway_wh_conc_arbiter.sv
// tb_bsg_gateway_wh_conc_arbiter: vector table, directed corner sequences and a randomized packet-level reference model
module tb_bsg_gateway_wh_conc_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  bsg_gateway_wh_conc_arbiter_if #(.num_in_p(N), .flit_width_p(32)) io();
  bsg_gateway_wh_conc_arbiter #(
    .num_in_p(N), .flit_width_p(32), .cord_width_p(5), .len_width_p(4), .cid_width_p(4)
  ) dut (.clk_i(clk), .reset_n_i(rst_n), .io(io));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] v; logic rdy; int rcid; logic rv; logic [3:0] rrdy;
    logic ov; int g; logic [3:0] ird; logic [3:0] erv; logic erdy;
  } vec_t;
  vec_t tbl[8];
  logic [31:0] fq[N][$];
  logic [31:0] rq[$];
  function automatic logic [31:0] mk(int cid, int len, int pay);
    return (32'(pay) << 13) | (32'(cid & 15) << 9) | (32'(len & 15) << 5) | 32'(pay & 31);
  endfunction
  function automatic logic [31:0] set_cid(logic [31:0] f, int c);
    return (f & ~32'h0000_1E00) | (32'(c) << 9);
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle_in();
    io.in_v_i = '0;
    io.in_data_i = '0;
    io.out_ready_and_i = 1'b0;
    io.rsp_v_i = 1'b0;
    io.rsp_data_i = '0;
    io.rsp_ready_and_i = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  int own, rem, rr, held, rmode, rd, rrem, g, dd, tgt, len;
  bit err, hdr, ev, rdy, drp, rv, erdy;
  logic [3:0] v;
  logic [31:0] ed, rdat, erv, d3;
  initial begin
    tbl[0] = '{4'b0000, 1'b0, 3, 1'b0, 4'b1000, 1'b0, 0, 4'b0000, 4'b0000, 1'b1};
    tbl[1] = '{4'b0100, 1'b1, 2, 1'b1, 4'b0100, 1'b1, 2, 4'b0100, 4'b0100, 1'b1};
    tbl[2] = '{4'b1010, 1'b1, 1, 1'b1, 4'b0100, 1'b1, 1, 4'b0010, 4'b0010, 1'b0};
    tbl[3] = '{4'b1000, 1'b0, 9, 1'b1, 4'b0000, 1'b1, 3, 4'b0000, 4'b0000, 1'b1};
    tbl[4] = '{4'b1111, 1'b1, 0, 1'b1, 4'b0001, 1'b1, 0, 4'b0001, 4'b0001, 1'b1};
    tbl[5] = '{4'b0001, 1'b1, 4, 1'b0, 4'b0000, 1'b1, 0, 4'b0001, 4'b0000, 1'b1};
    tbl[6] = '{4'b1100, 1'b1, 3, 1'b1, 4'b0111, 1'b1, 2, 4'b0100, 4'b1000, 1'b0};
    tbl[7] = '{4'b0110, 1'b0, 15, 1'b1, 4'b1111, 1'b1, 1, 4'b0000, 4'b0000, 1'b1};
    #1 rst_n = 1'b0;
    io.in_v_i = '1;
    for (int i = 0; i < N; i++) io.in_data_i[i] = mk(15, 2, i);
    io.out_ready_and_i = 1'b1;
    io.rsp_v_i = 1'b1;
    io.rsp_data_i = mk(1, 0, 5);
    io.rsp_ready_and_i = '1;
    #2;
    chk("reset_out_v", io.out_v_o, 0);
    chk("reset_in_ready", io.in_ready_and_o, 0);
    chk("reset_rsp_v", io.rsp_v_o, 0);
    chk("reset_rsp_ready", io.rsp_ready_and_o, 0);
    chk("reset_rsp_err", io.rsp_err_o, 0);
    for (int t = 0; t < 8; t++) begin
      do_reset();
      io.in_v_i = tbl[t].v;
      for (int i = 0; i < N; i++) io.in_data_i[i] = mk(15, 0, 'h100 + i);
      io.out_ready_and_i = tbl[t].rdy;
      io.rsp_v_i = tbl[t].rv;
      io.rsp_data_i = mk(tbl[t].rcid, 0, 'h55 + t);
      io.rsp_ready_and_i = tbl[t].rrdy;
      @(negedge clk);
      chk("tbl_out_v", io.out_v_o, tbl[t].ov);
      chk("tbl_in_ready", io.in_ready_and_o, tbl[t].ird);
      if (tbl[t].ov) chk("tbl_out_data", io.out_data_o, set_cid(mk(15, 0, 'h100 + tbl[t].g), tbl[t].g));
      chk("tbl_rsp_v", io.rsp_v_o, tbl[t].erv);
      chk("tbl_rsp_ready", io.rsp_ready_and_o, tbl[t].erdy);
      chk("tbl_rsp_data", io.rsp_data_o, mk(tbl[t].rcid, 0, 'h55 + t));
    end
    do_reset();
    io.in_v_i = 4'b0100;
    io.in_data_i[2] = mk(7, 0, 'h3a);
    io.out_ready_and_i = 1'b1;
    @(negedge clk);
    chk("basic_out_data", io.out_data_o, set_cid(mk(7, 0, 'h3a), 2));
    chk("basic_in_ready", io.in_ready_and_o, 4'b0100);
    step();
    io.in_v_i = '0;
    io.rsp_v_i = 1'b1;
    io.rsp_data_i = mk(2, 0, 'h77);
    io.rsp_ready_and_i = 4'b0100;
    @(negedge clk);
    chk("basic_rsp_v", io.rsp_v_o, 4'b0100);
    chk("basic_rsp_ready", io.rsp_ready_and_o, 1);
    do_reset();
    io.in_v_i = '1;
    for (int i = 0; i < N; i++) io.in_data_i[i] = mk(15, 0, i + 16);
    io.out_ready_and_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_in_ready", io.in_ready_and_o, 1 << (c % 4));
      d3 = io.out_data_o;
      chk("rr_cid", d3[12:9], c % 4);
      step();
    end
    do_reset();
    io.in_v_i = 4'b0001;
    io.in_data_i[0] = mk(0, 0, 1);
    io.out_ready_and_i = 1'b1;
    @(negedge clk);
    chk("lock_pre", io.in_ready_and_o, 4'b0001);
    step();
    io.in_v_i = 4'b0011;
    io.in_data_i[0] = mk(0, 0, 2);
    io.in_data_i[1] = mk(5, 3, 'h10);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lock_in_ready", io.in_ready_and_o, 4'b0010);
      chk("lock_data", io.out_data_o, (c == 0) ? set_cid(mk(5, 3, 'h10), 1) : mk(5, c, 'h20 + c));
      step();
      io.in_data_i[1] = mk(5, c + 1, 'h21 + c);
    end
    io.in_v_i = 4'b0001;
    @(negedge clk);
    chk("lock_after", io.in_ready_and_o, 4'b0001);
    do_reset();
    io.in_v_i = 4'b1000;
    io.in_data_i[3] = mk(6, 0, 'h33);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_out_v", io.out_v_o, 1);
      chk("hold_in_ready", io.in_ready_and_o, 0);
      step();
    end
    io.in_v_i = 4'b1001;
    io.in_data_i[0] = mk(6, 0, 'h44);
    @(negedge clk);
    chk("hold_keep", io.out_data_o, set_cid(mk(6, 0, 'h33), 3));
    step();
    io.out_ready_and_i = 1'b1;
    @(negedge clk);
    chk("hold_release", io.in_ready_and_o, 4'b1000);
    chk("hold_data", io.out_data_o, set_cid(mk(6, 0, 'h33), 3));
    step();
    io.in_v_i = 4'b0001;
    @(negedge clk);
    chk("hold_next", io.in_ready_and_o, 4'b0001);
    do_reset();
    io.rsp_v_i = 1'b1;
    io.rsp_data_i = mk(9, 2, 5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bad_rsp_ready", io.rsp_ready_and_o, 1);
      chk("bad_rsp_v", io.rsp_v_o, 0);
      step();
      io.rsp_data_i = mk(1, 0, 'h60 + c);
    end
    io.rsp_data_i = mk(1, 0, 'h70);
    io.rsp_ready_and_i = 4'b0010;
    @(negedge clk);
    chk("bad_err", io.rsp_err_o, 1);
    chk("bad_next_v", io.rsp_v_o, 4'b0010);
    chk("bad_next_ready", io.rsp_ready_and_o, 1);
    do_reset();
    io.in_v_i = 4'b0001;
    io.in_data_i[0] = mk(3, 5, 9);
    io.out_ready_and_i = 1'b1;
    @(negedge clk);
    chk("mid_hdr", io.in_ready_and_o, 4'b0001);
    step();
    io.in_data_i[0] = mk(3, 1, 'ha);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_v", io.out_v_o, 0);
    chk("mid_in_ready", io.in_ready_and_o, 0);
    chk("mid_rsp_ready", io.rsp_ready_and_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    io.in_data_i[0] = mk(3, 0, 'hb);
    @(negedge clk);
    chk("mid_after_hdr", io.out_data_o, set_cid(mk(3, 0, 'hb), 0));
    step();
    io.in_data_i[0] = mk(3, 0, 'hc);
    @(negedge clk);
    chk("mid_after_hdr2", io.out_data_o, set_cid(mk(3, 0, 'hc), 0));
    do_reset();
    own = -1; rem = 0; rr = 0; held = -1;
    rmode = 0; rd = 0; rrem = 0; err = 0;
    v = '0; rv = 0;
    for (int i = 0; i < N; i++) fq[i].delete();
    rq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (fq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
          fq[i].push_back(mk(int'($urandom_range(0, 15)), len, int'($urandom)));
          repeat (len) fq[i].push_back($urandom);
        end
        if (!v[i] && fq[i].size() > 0 && $urandom_range(0, 2) != 0) v[i] = 1'b1;
        io.in_data_i[i] = v[i] ? fq[i][0] : 32'h0;
      end
      io.in_v_i = v;
      rdy = $urandom_range(0, 3) != 0;
      io.out_ready_and_i = rdy;
      if (rq.size() == 0 && $urandom_range(0, 3) == 0) begin
        len = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
        rq.push_back(mk(int'($urandom_range(0, 5)), len, int'($urandom)));
        repeat (len) rq.push_back($urandom);
      end
      if (!rv && rq.size() > 0 && $urandom_range(0, 2) != 0) rv = 1;
      rdat = rv ? rq[0] : $urandom;
      io.rsp_v_i = rv;
      io.rsp_data_i = rdat;
      io.rsp_ready_and_i = 4'($urandom);
      @(negedge clk);
      if (own >= 0) begin
        g = own; hdr = 0; ev = v[g];
      end else if (held >= 0) begin
        g = held; hdr = 1; ev = v[g];
      end else begin
        g = -1;
        for (int j = N - 1; j >= 0; j--) if (v[(rr + j) % N]) g = (rr + j) % N;
        hdr = 1; ev = g >= 0;
      end
      chk("rnd_out_v", io.out_v_o, ev);
      chk("rnd_in_ready", io.in_ready_and_o & v, (ev && rdy) ? 32'(1) << g : 32'h0);
      if (ev) begin
        ed = hdr ? set_cid(fq[g][0], g) : fq[g][0];
        chk("rnd_out_data", io.out_data_o, ed);
      end
      if (ev && rdy) begin
        if (hdr) begin
          rr = (g + 1) % N;
          held = -1;
          rem = int'(fq[g][0][8:5]);
          if (rem > 0) own = g;
        end else begin
          rem--;
          if (rem == 0) own = -1;
        end
        void'(fq[g].pop_front());
        v[g] = 1'b0;
      end else if (ev && hdr) held = g;
      dd = int'(rdat[12:9]);
      if (rmode == 0) begin
        tgt = dd; drp = dd >= N;
      end else begin
        tgt = rd; drp = rmode == 2;
      end
      erv = (rv && !drp) ? 32'(1) << tgt : 32'h0;
      erdy = drp ? 1'b1 : io.rsp_ready_and_i[tgt];
      chk("rnd_rsp_v", io.rsp_v_o, erv);
      chk("rnd_rsp_ready", io.rsp_ready_and_o, erdy);
      chk("rnd_rsp_err", io.rsp_err_o, err);
      chk("rnd_rsp_data", io.rsp_data_o, rdat);
      if (rv && erdy) begin
        if (rmode == 0) begin
          if (drp) err = 1;
          rrem = int'(rdat[8:5]);
          rd = tgt;
          if (rrem > 0) rmode = drp ? 2 : 1;
        end else begin
          rrem--;
          if (rrem == 0) rmode = 0;
        end
        void'(rq.pop_front());
        rv = 0;
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_gateway_wh_conc_arbiter.md
# bsg_gateway_wh_conc_arbiter

Parametrised gateway-side wormhole concentrator. It merges `num_in_p` wormhole request links onto one test-memory port and routes response packets back to the originating link. The forward direction uses packet-locked round-robin arbitration. The response direction is demultiplexed by the `cid` field. It sits between the chip's per-ruche wormhole links and a single `bsg_nonsynth_wormhole_test_mem` running with concentration enabled, which replaces one test memory per link.

## Interface
- `num_in_p`, default 4: number of concentrated links; must be 2..16.
- `flit_width_p`, default `wh_flit_width_gp`: flit width.
- `cord_width_p`, default `wh_cord_width_gp`: header bits `[cord_width_p-1:0]`.
- `len_width_p`, default `wh_len_width_gp`: header bits above `cord`; the value is the number of body flits.
- `cid_width_p`, default `wh_cid_width_gp`: header bits above `len`; must be at least `clog2(num_in_p)`.
- `clk_i` input, 1 bit: single clock.
- `reset_n_i` input, 1 bit: asynchronous, active-low reset.
- `in_v_i` input, `[num_in_p]`: request flit valid per link.
- `in_data_i` input, `[num_in_p][flit_width_p]`: request flits.
- `in_ready_and_o` output, `[num_in_p]`: request accept per link.
- `out_v_o` output, 1 bit: concentrated request valid.
- `out_data_o` output, `flit_width_p`: concentrated request flit.
- `out_ready_and_i` input, 1 bit: memory accepts the flit.
- `rsp_v_i` input, 1 bit: response flit from memory.
- `rsp_data_i` input, `flit_width_p`: response flit.
- `rsp_ready_and_o` output, 1 bit: response accept.
- `rsp_v_o` output, `[num_in_p]`: per-link response valid.
- `rsp_data_o` output, `flit_width_p`: response flit, broadcast to all links.
- `rsp_ready_and_i` input, `[num_in_p]`: per-link response accept.
- `rsp_err_o` output, 1 bit: sticky flag for a bad response `cid`.

## Operation
- **Handshake:** a transfer occurs when valid and ready_and are both high in the same cycle. Senders hold valid and data until the transfer completes.
- **Forward path, `FWD_IDLE`:**
  - The grant goes to the first valid input at or after `rr_ptr`, wrapping modulo `num_in_p`.
  - `out_v_o` is the OR of all `in_v_i`.
  - `out_data_o` is the granted flit, with its `cid` field overwritten by the granted index, zero-extended.
  - `in_ready_and_o[g] = out_ready_and_i` for the granted input only; all other inputs see 0.
- **Header offered, not accepted** (`out_v_o=1`, `out_ready_and_i=0`): register the grant in `hold_g` and go to `FWD_HOLD`. Newly valid higher-priority inputs do not preempt it.
- **Header transfer:** set `rr_ptr = g+1` (mod `num_in_p`).
  - If `len == 0`, go to `FWD_IDLE`.
  - Otherwise load `fwd_cnt = len` and go to `FWD_BODY` with `g` locked.
- **`FWD_HOLD`:** behaves like the header phase but with `g = hold_g`. It transitions exactly as `FWD_IDLE` does on the header transfer.
- **`FWD_BODY`:**
  - Only `g` is connected; data passes through unmodified.
  - Each transfer decrements `fwd_cnt`.
  - The transfer with `fwd_cnt == 1` returns the FSM to `FWD_IDLE`.
- **Response path, `RSP_IDLE`:**
  - Compute `d = rsp_data_i` `cid` field.
  - If `d < num_in_p`: `rsp_v_o[d] = rsp_v_i` and `rsp_ready_and_o = rsp_ready_and_i[d]`.
  - On the header transfer with `len > 0`, lock `d`, load `rsp_cnt = len`, and go to `RSP_BODY`.
- **Bad `cid`** (`d >= num_in_p`) on a header with valid: set `rsp_ready_and_o = 1` and assert no `rsp_v_o`. Set `rsp_err_o` (sticky). Then discard the `len` body flits in `RSP_DROP`, counting them the same way.
- **`RSP_BODY`:** routes to the locked `d` and counts down as in `FWD_BODY`.
- The forward and response FSMs are independent; simultaneous activity on both paths is legal.
- `rsp_data_o` is always driven equal to `rsp_data_i`.

## Timing
- Both paths are combinational pass-through with zero added latency. There are no storage FIFOs.
- Registered state: forward FSM, `rr_ptr`, `hold_g`, `fwd_cnt`, response FSM, locked `d`, `rsp_cnt`, `rsp_err_o`.
- **Reset values** (asynchronous, while `reset_n_i=0`): all FSMs idle, `rr_ptr=0`, counters 0, `rsp_err_o=0`.
- **Outputs during reset:** all valid and ready outputs are 0.
- **Reset mid-packet:** the in-progress packet is abandoned. The first flit after reset is treated as a header.
- **Counter width:** `len_width_p`; a maximum `len` of `2^len_width_p - 1` must count correctly.
- **Pointer wrap:** when `g = num_in_p-1`, `rr_ptr` wraps to 0.
- **Fairness:** with all inputs continuously valid, grants rotate 0,1,...,`num_in_p-1`.

## Test plan
- **Basic routing:** after reset, send a single header (`len=0`, `cid=7`) on link 2. Expect `out_data_o` to carry `cid=2` in the same cycle, and a later response with `cid=2` to appear only on `rsp_v_o[2]`.
- **Round-robin:** hold all four links valid with `len=0` headers for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3.
- **Packet lock:** send link 1 with `len=3` while link 0 is valid. Expect 4 consecutive transfers from link 1, then link 2 or link 0 according to `rr_ptr=2`; link 0 must not interleave.
- **Hold and backpressure:** offer link 3's header with `out_ready_and_i=0` for 5 cycles, then raise link 0's valid. Expect link 3 to be transferred first once ready rises.
- **Bad `cid` response:** send a response with `cid=9`, `len=2`. Expect 3 flits consumed, no `rsp_v_o` asserted, `rsp_err_o=1` thereafter, and the next response with `cid=1` delivered normally.
- **Reset mid-packet:** assert `reset_n_i=0` during the body of a `len=5` packet. Expect all outputs 0 immediately, and after release the next flit on link 0 to be handled as a header.
